// File: rtl/imu_burst_reader.sv
// imu_burst_reader: waits for a sensor data-ready edge, reads a burst of
// N_CH words over SPI mode 0 starting at BASE_ADDR, then streams the words
// out over a valid/ready interface, channel 0 first.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   en              block enable; low returns to IDLE and clears overrun
//   data_ready      asynchronous sensor data-ready line
//   sclk, cs_n      SPI clock (idle low) and active-low chip select
//   mosi, miso      SPI data out / in
//   msg_valid       output word valid
//   msg_ready       consumer accepts a word when high with msg_valid
//   msg_data        sensor word
//   msg_chan        channel index of msg_data
//   busy            high while a burst is being read or emitted
//   overrun         sticky: data_ready rose while busy
module imu_burst_reader #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned N_CH      = 3,
  parameter int unsigned DATA_W    = 16,
  parameter logic [6:0]  BASE_ADDR = 7'h22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              data_ready,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic              msg_valid,
  input  logic              msg_ready,
  output logic [DATA_W-1:0] msg_data,
  output logic [3:0]        msg_chan,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned TOTAL_BITS = 8 + N_CH * DATA_W;
  localparam int unsigned BUF_W      = N_CH * DATA_W;
  localparam int unsigned BC_W       = $clog2(TOTAL_BITS + 1);
  localparam int unsigned CH_W       = 4;

  localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(TOTAL_BITS - 1);
  localparam logic [BC_W-1:0] CMD_BITS = BC_W'(8);
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [7:0]      CMD      = {1'b1, BASE_ADDR};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DRDY,
    S_CS_SETUP,
    S_XFER,
    S_CS_HOLD,
    S_EMIT
  } state_t;

  state_t            state_q, state_d;
  logic              drdy_meta_q, drdy_meta_d;
  logic              drdy_sync_q, drdy_sync_d;
  logic              drdy_prev_q, drdy_prev_d;
  logic [7:0]        div_cnt_q, div_cnt_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              sclk_hi_q, sclk_hi_d;
  logic [7:0]        cmd_sr_q, cmd_sr_d;
  logic [BUF_W-1:0]  shift_q, shift_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              msg_valid_q, msg_valid_d;
  logic [DATA_W-1:0] msg_data_q, msg_data_d;
  logic [CH_W-1:0]   msg_chan_q, msg_chan_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              drdy_rise;
  logic [CH_W-1:0]   sel_ch;
  logic [DATA_W-1:0] sel_word;

  assign drdy_rise = drdy_sync_q & ~drdy_prev_q;

  // Word the emitter will present next: ch 0 on entry, ch+1 while emitting.
  always_comb begin
    sel_ch   = (state_q == S_EMIT) ? CH_W'(msg_chan_q + 4'd1) : '0;
    sel_word = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (sel_ch == CH_W'(k)) begin
        sel_word = shift_q[(int'(N_CH) - 1 - k) * int'(DATA_W) +: DATA_W];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    drdy_meta_d = data_ready;
    drdy_sync_d = drdy_meta_q;
    drdy_prev_d = drdy_sync_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sclk_hi_d   = sclk_hi_q;
    cmd_sr_d    = cmd_sr_q;
    shift_d     = shift_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    msg_valid_d = msg_valid_q;
    msg_data_d  = msg_data_q;
    msg_chan_d  = msg_chan_q;
    overrun_d   = overrun_q;

    if (!en) begin
      // Abort anything in flight; captured words stay in the buffer.
      state_d     = S_IDLE;
      cs_n_d      = 1'b1;
      sclk_d      = 1'b0;
      sclk_hi_d   = 1'b0;
      mosi_d      = 1'b0;
      div_cnt_d   = '0;
      msg_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      if (drdy_rise && busy_q) begin
        overrun_d = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_DRDY;
        end

        S_WAIT_DRDY: begin
          if (drdy_rise) begin
            state_d   = S_CS_SETUP;
            cs_n_d    = 1'b0;
            div_cnt_d = '0;
          end
        end

        S_CS_SETUP: begin
          if (div_cnt_q == DIV_LAST) begin
            state_d   = S_XFER;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            sclk_hi_d = 1'b0;
            mosi_d    = CMD[7];
            cmd_sr_d  = {CMD[6:0], 1'b0};
          end else begin
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end

        S_XFER: begin
          if (div_cnt_q != DIV_LAST) begin
            div_cnt_d = div_cnt_q + 8'd1;
          end else begin
            div_cnt_d = '0;
            if (!sclk_hi_q) begin
              // Rising sclk: sample miso; command-phase bits are dropped.
              sclk_d    = 1'b1;
              sclk_hi_d = 1'b1;
              if (bit_cnt_q >= CMD_BITS) begin
                shift_d = {shift_q[BUF_W-2:0], miso};
              end
            end else begin
              sclk_d    = 1'b0;
              sclk_hi_d = 1'b0;
              if (bit_cnt_q == BIT_LAST) begin
                state_d = S_CS_HOLD;
                mosi_d  = 1'b0;
              end else begin
                // Next low phase: shift out the command, zeros once drained.
                bit_cnt_d = bit_cnt_q + 1'b1;
                mosi_d    = cmd_sr_q[7];
                cmd_sr_d  = {cmd_sr_q[6:0], 1'b0};
              end
            end
          end
        end

        S_CS_HOLD: begin
          if (div_cnt_q == DIV_LAST) begin
            state_d     = S_EMIT;
            div_cnt_d   = '0;
            cs_n_d      = 1'b1;
            msg_valid_d = 1'b1;
            msg_chan_d  = '0;
            msg_data_d  = sel_word;
          end else begin
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end

        S_EMIT: begin
          if (msg_valid_q && msg_ready) begin
            if (msg_chan_q == CH_LAST) begin
              msg_valid_d = 1'b0;
              state_d     = S_WAIT_DRDY;
            end else begin
              msg_chan_d = sel_ch;
              msg_data_d = sel_word;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_CS_SETUP) || (state_d == S_XFER) ||
             (state_d == S_CS_HOLD)  || (state_d == S_EMIT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drdy_meta_q <= 1'b0;
      drdy_sync_q <= 1'b0;
      drdy_prev_q <= 1'b0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      sclk_hi_q   <= 1'b0;
      cmd_sr_q    <= '0;
      shift_q     <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      msg_valid_q <= 1'b0;
      msg_data_q  <= '0;
      msg_chan_q  <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drdy_meta_q <= drdy_meta_d;
      drdy_sync_q <= drdy_sync_d;
      drdy_prev_q <= drdy_prev_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sclk_hi_q   <= sclk_hi_d;
      cmd_sr_q    <= cmd_sr_d;
      shift_q     <= shift_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      msg_valid_q <= msg_valid_d;
      msg_data_q  <= msg_data_d;
      msg_chan_q  <= msg_chan_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign mosi      = mosi_q;
  assign msg_valid = msg_valid_q;
  assign msg_data  = msg_data_q;
  assign msg_chan  = msg_chan_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_imu_burst_reader.sv
// Bench for imu_burst_reader: three instances (CLK_DIV 2, 1, 4), each with a
// mode-0 SPI sensor model returning 16'h1234, 16'h5678, 16'h9ABC.
module tb_imu_burst_reader;

  logic        clk;
  logic        rst;
  logic [2:0]  en;
  logic        data_ready;
  logic        msg_ready;
  logic [2:0]  sclk, cs_n, mosi, msg_valid, busy, overrun;
  logic [15:0] msg_data [3];
  logic [3:0]  msg_chan [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_w [3] = '{16'h1234, 16'h5678, 16'h9ABC};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic        sl_miso   = 1'b0;
    logic [55:0] sr        = '0;
    logic        prev_cs   = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [7:0]  cap       = '0;
    int          rises     = 0;
    int          bursts    = 0;

    imu_burst_reader #(
      .CLK_DIV(DIV), .N_CH(3), .DATA_W(16), .BASE_ADDR(7'h22)
    ) u_dut (
      .clk(clk), .rst(rst), .en(en[g]), .data_ready(data_ready),
      .sclk(sclk[g]), .cs_n(cs_n[g]), .mosi(mosi[g]), .miso(sl_miso),
      .msg_valid(msg_valid[g]), .msg_ready(msg_ready),
      .msg_data(msg_data[g]), .msg_chan(msg_chan[g]),
      .busy(busy[g]), .overrun(overrun[g])
    );

    // Sensor model: 8 don't-care bits during the command, then three words.
    always @(cs_n[g] or sclk[g]) begin
      if (prev_cs === 1'b1 && cs_n[g] === 1'b0) begin
        sr      = 56'h00_1234_5678_9ABC;
        sl_miso = sr[55];
        rises   = 0;
        cap     = '0;
        bursts  = bursts + 1;
      end else if (cs_n[g] === 1'b0 && prev_sclk === 1'b1 && sclk[g] === 1'b0) begin
        sr      = {sr[54:0], 1'b0};
        sl_miso = sr[55];
      end
      if (cs_n[g] === 1'b0 && prev_sclk === 1'b0 && sclk[g] === 1'b1) begin
        if (rises < 8) cap = {cap[6:0], mosi[g]};
        rises = rises + 1;
      end
      prev_cs   = cs_n[g];
      prev_sclk = sclk[g];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_drdy();
    data_ready = 1'b1;
    tick(3);
    data_ready = 1'b0;
  endtask

  task automatic wait_cs_low(input int budget);
    for (int i = 0; i < budget && cs_n[0] !== 1'b0; i++) tick(1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && msg_valid[0] !== 1'b1; i++) tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    n_checks++; if (sclk[0] !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b want 0", sclk[0]); end
    n_checks++; if (cs_n[0] !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: got %b want 1", cs_n[0]); end
    n_checks++; if (mosi[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", mosi[0]); end
    n_checks++; if (msg_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", msg_valid[0]); end
    n_checks++; if (msg_data[0] !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0000", msg_data[0]); end
    n_checks++; if (msg_chan[0] !== 4'h0) begin n_fail++; $display("FAIL rst_chan: got %h want 0", msg_chan[0]); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy[0]); end
    n_checks++; if (overrun[0] !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun[0]); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic_burst();
    int b0;
    en[0] = 1'b1;
    msg_ready = 1'b1;
    tick(2);
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL wait_busy: got %b want 0", busy[0]); end
    b0 = g_dut[0].bursts;
    pulse_drdy();
    wait_cs_low(20);
    n_checks++; if (cs_n[0] !== 1'b0) begin n_fail++; $display("FAIL basic_cs_fall: got %b want 0", cs_n[0]); end
    n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy[0]); end
    wait_valid(400);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (msg_valid[0] !== 1'b1) begin n_fail++; $display("FAIL basic_valid%0d: got %b want 1", k, msg_valid[0]); end
      n_checks++; if (msg_chan[0] !== 4'(k)) begin n_fail++; $display("FAIL basic_chan%0d: got %0d want %0d", k, msg_chan[0], k); end
      n_checks++; if (msg_data[0] !== exp_w[k]) begin n_fail++; $display("FAIL basic_data%0d: got %h want %h", k, msg_data[0], exp_w[k]); end
      tick(1);
    end
    n_checks++; if (msg_valid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", msg_valid[0]); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy[0]); end
    n_checks++; if (cs_n[0] !== 1'b1) begin n_fail++; $display("FAIL basic_cs_end: got %b want 1", cs_n[0]); end
    n_checks++; if (g_dut[0].cap !== 8'hA2) begin n_fail++; $display("FAIL basic_cmd: got %h want a2", g_dut[0].cap); end
    n_checks++; if (g_dut[0].rises !== 56) begin n_fail++; $display("FAIL basic_rises: got %0d want 56", g_dut[0].rises); end
    n_checks++; if (g_dut[0].bursts - b0 !== 1) begin n_fail++; $display("FAIL basic_bursts: got %0d want 1", g_dut[0].bursts - b0); end
    n_checks++; if (overrun[0] !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b want 0", overrun[0]); end
  endtask

  task automatic test_backpressure();
    msg_ready = 1'b0;
    pulse_drdy();
    wait_valid(400);
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (msg_valid[0] !== 1'b1 || msg_data[0] !== 16'h1234 || msg_chan[0] !== 4'h0) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b d=%h c=%0d want v=1 d=1234 c=0", i, msg_valid[0], msg_data[0], msg_chan[0]);
      end
      tick(1);
    end
    msg_ready = 1'b1;
    tick(1);
    n_checks++; if (msg_chan[0] !== 4'h1 || msg_data[0] !== 16'h5678) begin n_fail++; $display("FAIL bp_ch1: got c=%0d d=%h want c=1 d=5678", msg_chan[0], msg_data[0]); end
    tick(1);
    n_checks++; if (msg_chan[0] !== 4'h2 || msg_data[0] !== 16'h9ABC) begin n_fail++; $display("FAIL bp_ch2: got c=%0d d=%h want c=2 d=9abc", msg_chan[0], msg_data[0]); end
    tick(1);
    n_checks++; if (msg_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", msg_valid[0]); end
  endtask

  task automatic test_overrun();
    int b0;
    int words;
    msg_ready = 1'b1;
    b0 = g_dut[0].bursts;
    pulse_drdy();
    wait_cs_low(20);
    tick(20);
    n_checks++; if (overrun[0] !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b want 0", overrun[0]); end
    pulse_drdy();
    tick(3);
    n_checks++; if (overrun[0] !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun[0]); end
    n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL ovr_busy: got %b want 1", busy[0]); end
    wait_valid(400);
    words = 0;
    for (int i = 0; i < 10 && msg_valid[0] === 1'b1; i++) begin
      words++;
      tick(1);
    end
    n_checks++; if (words !== 3) begin n_fail++; $display("FAIL ovr_words: got %0d want 3", words); end
    tick(100);
    n_checks++; if (g_dut[0].bursts - b0 !== 1) begin n_fail++; $display("FAIL ovr_bursts: got %0d want 1", g_dut[0].bursts - b0); end
    n_checks++; if (overrun[0] !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun[0]); end
    en[0] = 1'b0;
    tick(1);
    n_checks++; if (overrun[0] !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun[0]); end
    en[0] = 1'b1;
    tick(1);
  endtask

  task automatic test_en_drop_emit();
    int extra;
    msg_ready = 1'b0;
    pulse_drdy();
    wait_valid(400);
    msg_ready = 1'b1;
    tick(1);
    n_checks++; if (msg_chan[0] !== 4'h1) begin n_fail++; $display("FAIL endrop_ch1: got %0d want 1", msg_chan[0]); end
    en[0] = 1'b0;
    tick(1);
    n_checks++; if (msg_valid[0] !== 1'b0) begin n_fail++; $display("FAIL endrop_valid: got %b want 0", msg_valid[0]); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL endrop_busy: got %b want 0", busy[0]); end
    n_checks++; if (cs_n[0] !== 1'b1) begin n_fail++; $display("FAIL endrop_cs: got %b want 1", cs_n[0]); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (msg_valid[0] === 1'b1) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL endrop_extra: got %0d want 0", extra); end
    en[0] = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid_xfer();
    msg_ready = 1'b1;
    pulse_drdy();
    wait_cs_low(20);
    tick(30);
    for (int i = 0; i < 20 && sclk[0] !== 1'b1; i++) tick(1);
    n_checks++; if (sclk[0] !== 1'b1) begin n_fail++; $display("FAIL rmx_sclk_high: got %b want 1", sclk[0]); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (cs_n[0] !== 1'b1) begin n_fail++; $display("FAIL rmx_cs_async: got %b want 1", cs_n[0]); end
    n_checks++; if (sclk[0] !== 1'b0) begin n_fail++; $display("FAIL rmx_sclk_async: got %b want 0", sclk[0]); end
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    n_checks++; if (busy[0] !== 1'b0 || msg_data[0] !== 16'h0) begin n_fail++; $display("FAIL rmx_after: got busy=%b d=%h want busy=0 d=0000", busy[0], msg_data[0]); end
    pulse_drdy();
    wait_valid(400);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (msg_valid[0] !== 1'b1 || msg_chan[0] !== 4'(k) || msg_data[0] !== exp_w[k]) begin
        n_fail++; $display("FAIL rmx_word%0d: got v=%b c=%0d d=%h want v=1 c=%0d d=%h", k, msg_valid[0], msg_chan[0], msg_data[0], k, exp_w[k]);
      end
      tick(1);
    end
    n_checks++; if (g_dut[0].rises !== 56) begin n_fail++; $display("FAIL rmx_rises: got %0d want 56", g_dut[0].rises); end
  endtask

  task automatic test_clkdiv();
    int hi_min [3];
    int hi_max [3];
    int lo_min [3];
    int lo_max [3];
    int cs_cnt [3];
    int run    [3];
    logic prev [3];
    logic seen [3];
    int exp_div [3] = '{2, 1, 4};
    int rc;
    for (int j = 0; j < 3; j++) begin
      hi_min[j] = 1000; hi_max[j] = 0; lo_min[j] = 1000; lo_max[j] = 0;
      cs_cnt[j] = 0; run[j] = 0; prev[j] = 1'b0; seen[j] = 1'b0;
    end
    en = 3'b110;
    msg_ready = 1'b1;
    tick(2);
    data_ready = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick(1);
      if (cyc == 2) data_ready = 1'b0;
      for (int j = 1; j < 3; j++) begin
        if (cs_n[j] === 1'b0) cs_cnt[j]++;
        if (sclk[j] === prev[j]) run[j]++;
        else begin
          if (prev[j] === 1'b1) begin
            if (run[j] < hi_min[j]) hi_min[j] = run[j];
            if (run[j] > hi_max[j]) hi_max[j] = run[j];
          end else if (seen[j]) begin
            if (run[j] < lo_min[j]) lo_min[j] = run[j];
            if (run[j] > lo_max[j]) lo_max[j] = run[j];
          end
          if (sclk[j] === 1'b1) seen[j] = 1'b1;
          run[j] = 1;
        end
        prev[j] = sclk[j];
      end
      if (cs_cnt[1] > 0 && cs_n[1] === 1'b1 && cs_cnt[2] > 0 && cs_n[2] === 1'b1) break;
    end
    for (int j = 1; j < 3; j++) begin
      rc = (j == 1) ? g_dut[1].rises : g_dut[2].rises;
      n_checks++; if (hi_min[j] !== exp_div[j] || hi_max[j] !== exp_div[j]) begin n_fail++; $display("FAIL div%0d_high: got %0d..%0d want %0d", exp_div[j], hi_min[j], hi_max[j], exp_div[j]); end
      n_checks++; if (lo_min[j] !== exp_div[j] || lo_max[j] !== exp_div[j]) begin n_fail++; $display("FAIL div%0d_low: got %0d..%0d want %0d", exp_div[j], lo_min[j], lo_max[j], exp_div[j]); end
      n_checks++; if (cs_cnt[j] < 114 * exp_div[j] || cs_cnt[j] > 114 * exp_div[j] + 2) begin n_fail++; $display("FAIL div%0d_cs_low: got %0d want %0d..%0d", exp_div[j], cs_cnt[j], 114 * exp_div[j], 114 * exp_div[j] + 2); end
      n_checks++; if (rc !== 56) begin n_fail++; $display("FAIL div%0d_rises: got %0d want 56", exp_div[j], rc); end
    end
    tick(10);
    en = 3'b001;
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    en         = 3'b000;
    data_ready = 1'b0;
    msg_ready  = 1'b0;
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_overrun();
    test_en_drop_emit();
    test_reset_mid_xfer();
    test_clkdiv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
